// File: rtl/unidade_pc_pkg.sv
// unidade_pc_pkg: shared branch-operation codes, FSM states and default datapath width
package pacote_pc;
    localparam int LARG_PADRAO = 8;
    typedef enum logic [2:0] {
        T_SEQ  = 3'd0,
        T_BEQ  = 3'd1,
        T_BNEG = 3'd2,
        T_JMP  = 3'd3,
        T_CALL = 3'd4,
        T_RET  = 3'd5,
        T_HALT = 3'd6
    } tipo_t;
    typedef enum logic [1:0] {
        EXEC   = 2'd0,
        PARADO = 2'd1,
        ERRO   = 2'd2
    } estado_t;
endpackage

// File: rtl/unidade_pc_if.sv
// unidade_pc_if: PC-stage bus; slave = unidade_pc (takes control/flags/targets, drives pc and status), master = driver
interface unidade_pc_if #(
    parameter int LARG       = pacote_pc::LARG_PADRAO,
    parameter int PROF_PILHA = 4
);
    localparam int PW = $clog2(PROF_PILHA) + 1;
    logic            habilita;
    logic [2:0]      tipo_desvio;
    logic            zero;
    logic            negativo;
    logic [LARG-1:0] offset;
    logic [LARG-1:0] alvo;
    logic            retoma;
    logic [LARG-1:0] pc;
    logic            desvio_tomado;
    logic            parado;
    logic            erro_pilha;
    logic [PW-1:0]   profundidade;
    modport slave (
        input  habilita, tipo_desvio, zero, negativo, offset, alvo, retoma,
        output pc, desvio_tomado, parado, erro_pilha, profundidade
    );
    modport master (
        output habilita, tipo_desvio, zero, negativo, offset, alvo, retoma,
        input  pc, desvio_tomado, parado, erro_pilha, profundidade
    );
endinterface

// File: rtl/unidade_pc_pilha.sv
// pilha_retorno: return-address LIFO; push/pop/dado_in in, topo/cheia/vazia/profundidade out; illegal push/pop ignored
module pilha_retorno #(
    parameter int LARG = 8,
    parameter int PROF = 4,
    localparam int IW  = $clog2(PROF),
    localparam int PW  = IW + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [LARG-1:0] dado_in,
    output logic [LARG-1:0] topo,
    output logic            cheia,
    output logic            vazia,
    output logic [PW-1:0]   profundidade
);
    logic [LARG-1:0] mem [PROF];
    logic [PW-1:0]   topo_idx;
    assign cheia    = profundidade == PW'(PROF);
    assign vazia    = profundidade == '0;
    assign topo_idx = profundidade - 1'b1;
    assign topo     = mem[topo_idx[IW-1:0]];
    // Entries need no reset: only slots below profundidade are ever read.
    always_ff @(posedge clock)
        if (push && !cheia) mem[profundidade[IW-1:0]] <= dado_in;
    always_ff @(posedge clock or posedge reset)
        if (reset) profundidade <= '0;
        else if (push && !cheia) profundidade <= profundidade + 1'b1;
        else if (pop && !vazia) profundidade <= profundidade - 1'b1;
endmodule

// File: rtl/unidade_pc.sv
// unidade_pc: registered PC with branch/jump/call/return/halt resolution; clock/reset plain, everything else on bus (slave)
module unidade_pc
    import pacote_pc::*;
#(
    parameter int              LARG       = LARG_PADRAO,
    parameter int              PROF_PILHA = 4,
    parameter logic [LARG-1:0] PC_RESET   = '0
) (
    input logic         clock,
    input logic         reset,
    unidade_pc_if.slave bus
);
    estado_t         estado, estado_n;
    logic [LARG-1:0] pc, pc_n, pc_mais1, pc_rel, topo;
    logic            tomado, tomado_n, push, pop, cheia, vazia;
    assign pc_mais1 = pc + 1'b1;
    // Same-width add modulo 2^LARG is identical to a sign-extended add.
    assign pc_rel   = pc_mais1 + bus.offset;
    pilha_retorno #(.LARG(LARG), .PROF(PROF_PILHA)) u_pilha (
        .clock(clock), .reset(reset), .push(push), .pop(pop), .dado_in(pc_mais1),
        .topo(topo), .cheia(cheia), .vazia(vazia), .profundidade(bus.profundidade)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            estado <= EXEC;
            pc     <= PC_RESET;
            tomado <= 1'b0;
        end else begin
            estado <= estado_n;
            pc     <= pc_n;
            tomado <= tomado_n;
        end
    always_comb begin
        estado_n = estado;
        pc_n     = pc;
        tomado_n = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        case (estado)
            EXEC: if (bus.habilita)
                case (bus.tipo_desvio)
                    T_BEQ: begin
                        pc_n     = bus.zero ? pc_rel : pc_mais1;
                        tomado_n = bus.zero;
                    end
                    T_BNEG: begin
                        pc_n     = bus.negativo ? pc_rel : pc_mais1;
                        tomado_n = bus.negativo;
                    end
                    T_JMP: begin
                        pc_n     = bus.alvo;
                        tomado_n = 1'b1;
                    end
                    T_CALL: begin
                        estado_n = cheia ? ERRO : EXEC;
                        push     = !cheia;
                        pc_n     = cheia ? pc : bus.alvo;
                        tomado_n = !cheia;
                    end
                    T_RET: begin
                        estado_n = vazia ? ERRO : EXEC;
                        pop      = !vazia;
                        pc_n     = vazia ? pc : topo;
                        tomado_n = !vazia;
                    end
                    T_HALT: estado_n = PARADO;
                    default: pc_n = pc_mais1;
                endcase
            PARADO: if (bus.retoma && bus.habilita) begin
                estado_n = EXEC;
                pc_n     = pc_mais1;
            end
            default: ;
        endcase
    end
    assign bus.pc            = pc;
    assign bus.desvio_tomado = tomado;
    assign bus.parado        = estado == PARADO;
    assign bus.erro_pilha    = estado == ERRO;
endmodule

// File: tb/tb_unidade_pc.sv
// tb_unidade_pc: directed self-checking bench for unidade_pc
module tb_unidade_pc;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clock = ~clock;
    unidade_pc_if #(.LARG(8), .PROF_PILHA(4)) bus ();
    unidade_pc #(.LARG(8), .PROF_PILHA(4), .PC_RESET(8'h00)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic passo(input logic [2:0] t, input logic [7:0] a, input logic [7:0] o,
                         input logic z, input logic n);
        bus.tipo_desvio = t;
        bus.alvo        = a;
        bus.offset      = o;
        bus.zero        = z;
        bus.negativo    = n;
        @(posedge clock);
        #1;
    endtask
    initial begin
        bus.habilita = 1'b1; bus.retoma = 1'b0; bus.tipo_desvio = 3'd0;
        bus.zero = 1'b0; bus.negativo = 1'b0; bus.offset = 8'h00; bus.alvo = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_tomado", {7'b0, bus.desvio_tomado}, 8'h00);
        chk("rst_parado", {7'b0, bus.parado}, 8'h00);
        chk("rst_erro", {7'b0, bus.erro_pilha}, 8'h00);
        chk("rst_prof", {5'b0, bus.profundidade}, 8'h00);
        reset = 1'b0;
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("seq1", bus.pc, 8'h01);
        chk("seq1_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("seq2", bus.pc, 8'h02);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("seq3", bus.pc, 8'h03);
        chk("seq3_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        reset = 1'b1;
        #1;
        chk("async_rst", bus.pc, 8'h00);
        reset = 1'b0;
        passo(3'd3, 8'h10, 8'h00, 0, 0); chk("jmp10", bus.pc, 8'h10);
        chk("jmp_tom", {7'b0, bus.desvio_tomado}, 8'h01);
        passo(3'd1, 8'h00, 8'hFC, 1, 0); chk("beq_t", bus.pc, 8'h0D);
        chk("beq_t_tom", {7'b0, bus.desvio_tomado}, 8'h01);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("pulse_end", {7'b0, bus.desvio_tomado}, 8'h00);
        chk("after_beq", bus.pc, 8'h0E);
        passo(3'd3, 8'h10, 8'h00, 0, 0);
        passo(3'd1, 8'h00, 8'hFC, 0, 0); chk("beq_nt", bus.pc, 8'h11);
        chk("beq_nt_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        passo(3'd3, 8'h20, 8'h00, 0, 0);
        passo(3'd2, 8'h00, 8'h05, 0, 1); chk("bneg_t", bus.pc, 8'h26);
        chk("bneg_tom", {7'b0, bus.desvio_tomado}, 8'h01);
        passo(3'd2, 8'h00, 8'h05, 1, 0); chk("bneg_nt", bus.pc, 8'h27);
        passo(3'd7, 8'h00, 8'h00, 0, 0); chk("reserved", bus.pc, 8'h28);
        passo(3'd3, 8'hFF, 8'h00, 0, 0);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("wrap", bus.pc, 8'h00);
        passo(3'd3, 8'hFE, 8'h00, 0, 0);
        passo(3'd1, 8'h00, 8'h7F, 1, 0); chk("beq_wrap", bus.pc, 8'h7E);
        bus.habilita = 1'b0;
        passo(3'd3, 8'h55, 8'h00, 0, 0); chk("stall_pc", bus.pc, 8'h7E);
        chk("stall_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        bus.habilita = 1'b1;
        passo(3'd3, 8'h05, 8'h00, 0, 0);
        passo(3'd4, 8'h40, 8'h00, 0, 0); chk("call1_pc", bus.pc, 8'h40);
        chk("call1_prof", {5'b0, bus.profundidade}, 8'h01);
        chk("call1_tom", {7'b0, bus.desvio_tomado}, 8'h01);
        passo(3'd4, 8'h40, 8'h00, 0, 0);
        passo(3'd4, 8'h40, 8'h00, 0, 0);
        passo(3'd4, 8'h40, 8'h00, 0, 0); chk("call4_prof", {5'b0, bus.profundidade}, 8'h04);
        chk("call4_erro", {7'b0, bus.erro_pilha}, 8'h00);
        passo(3'd4, 8'h77, 8'h00, 0, 0); chk("ovf_erro", {7'b0, bus.erro_pilha}, 8'h01);
        chk("ovf_pc", bus.pc, 8'h40);
        chk("ovf_prof", {5'b0, bus.profundidade}, 8'h04);
        chk("ovf_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("erro_hold", bus.pc, 8'h40);
        chk("erro_stay", {7'b0, bus.erro_pilha}, 8'h01);
        reset = 1'b1;
        #1;
        chk("erro_clr", {7'b0, bus.erro_pilha}, 8'h00);
        chk("erro_clr_prof", {5'b0, bus.profundidade}, 8'h00);
        reset = 1'b0;
        passo(3'd3, 8'h07, 8'h00, 0, 0);
        passo(3'd4, 8'h30, 8'h00, 0, 0); chk("call30", bus.pc, 8'h30);
        chk("call30_prof", {5'b0, bus.profundidade}, 8'h01);
        passo(3'd5, 8'h00, 8'h00, 0, 0); chk("ret_pc", bus.pc, 8'h08);
        chk("ret_prof", {5'b0, bus.profundidade}, 8'h00);
        chk("ret_tom", {7'b0, bus.desvio_tomado}, 8'h01);
        passo(3'd5, 8'h00, 8'h00, 0, 0); chk("udf_erro", {7'b0, bus.erro_pilha}, 8'h01);
        chk("udf_pc", bus.pc, 8'h08);
        chk("udf_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        passo(3'd3, 8'h12, 8'h00, 0, 0);
        passo(3'd6, 8'h00, 8'h00, 0, 0); chk("halt_par", {7'b0, bus.parado}, 8'h01);
        chk("halt_pc", bus.pc, 8'h12);
        chk("halt_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        passo(3'd3, 8'h99, 8'h00, 0, 0); chk("par1", bus.pc, 8'h12);
        passo(3'd4, 8'h99, 8'h00, 0, 0); chk("par2", bus.pc, 8'h12);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("par3", bus.pc, 8'h12);
        passo(3'd5, 8'h00, 8'h00, 0, 0); chk("par4", bus.pc, 8'h12);
        passo(3'd1, 8'h00, 8'h10, 1, 0); chk("par5", bus.pc, 8'h12);
        chk("par5_par", {7'b0, bus.parado}, 8'h01);
        chk("par_prof", {5'b0, bus.profundidade}, 8'h00);
        bus.retoma = 1'b1; bus.habilita = 1'b0;
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("ret_stall", {7'b0, bus.parado}, 8'h01);
        chk("ret_stall_pc", bus.pc, 8'h12);
        bus.habilita = 1'b1;
        passo(3'd3, 8'h99, 8'h00, 0, 0); chk("retoma_pc", bus.pc, 8'h13);
        chk("retoma_par", {7'b0, bus.parado}, 8'h00);
        chk("retoma_tom", {7'b0, bus.desvio_tomado}, 8'h00);
        passo(3'd0, 8'h00, 8'h00, 0, 0); chk("retoma_exec", bus.pc, 8'h14);
        bus.retoma = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
